// File: rtl/prng_sequencer.sv
// Sequencer around an external xoroshiro128+ core: seeding, priming, jump/long-jump
// and round-robin distribution of random words to N_REQ requesters.
module prng_sequencer #(
  parameter int unsigned N_REQ = 2
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_seedValid,
  input  logic [63:0]      i_seedS0,
  input  logic [63:0]      i_seedS1,
  input  logic             i_jump,
  input  logic             i_longJump,
  output logic             o_busy,
  output logic             o_seedErr,
  input  logic [N_REQ-1:0] i_req,
  output logic [N_REQ-1:0] o_gnt,
  output logic [63:0]      o_data,
  output logic             o_prngCg,
  output logic             o_prngSeedValid,
  output logic [63:0]      o_prngSeedS0,
  output logic [63:0]      o_prngSeedS1,
  input  logic [63:0]      i_prngS0,
  input  logic [63:0]      i_prngS1,
  input  logic [63:0]      i_prngResult
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [127:0] JUMP_POLY  = {64'h170865df4b3201fc, 64'hdf900294d8f554a5};
  localparam logic [127:0] LJUMP_POLY = {64'hdddf9b1090aa7ac1, 64'hd2a98b26625eee7b};

  typedef enum logic [2:0] {
    UNSEEDED,
    LOAD,
    PRIME,
    READY,
    JUMP
  } state_e;

  state_e           state_q, state_d;
  logic [127:0]     acc_q, acc_d;
  logic [6:0]       k_q, k_d;
  logic             long_q, long_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             seed_err_q, seed_err_d;

  logic             seed_ok;
  logic             found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W:0]   cand;
  logic [127:0]     poly;

  assign seed_ok = (|i_seedS0) || (|i_seedS1);

  // Round-robin search starting at ptr_q, wrapping modulo N_REQ.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(N_REQ)) cand = cand - (IDX_W+1)'(N_REQ);
      if (!found && i_req[cand[IDX_W-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    acc_d           = acc_q;
    k_d             = k_q;
    long_d          = long_q;
    ptr_d           = ptr_q;
    seed_err_d      = 1'b0;
    o_gnt           = '0;
    o_prngCg        = 1'b0;
    o_prngSeedValid = 1'b0;
    o_busy          = 1'b1;
    poly            = long_q ? LJUMP_POLY : JUMP_POLY;

    // acc_q doubles as the latched host seed, so LOAD always reads the same register.
    case (state_q)
      UNSEEDED: begin
        o_busy = 1'b0;
        if (i_seedValid) begin
          if (seed_ok) begin
            acc_d   = {i_seedS0, i_seedS1};
            state_d = LOAD;
          end else begin
            seed_err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        o_prngSeedValid = 1'b1;
        o_prngCg        = 1'b1;
        state_d         = PRIME;
      end
      PRIME: begin
        o_prngCg = 1'b1;
        state_d  = READY;
      end
      READY: begin
        o_busy = 1'b0;
        if (i_seedValid) begin
          if (seed_ok) begin
            acc_d   = {i_seedS0, i_seedS1};
            state_d = LOAD;
          end else begin
            seed_err_d = 1'b1;
          end
        end else if (i_longJump || i_jump) begin
          state_d = JUMP;
          long_d  = i_longJump;
          acc_d   = '0;
          k_d     = '0;
        end else if (found) begin
          o_gnt[win_idx] = 1'b1;
          o_prngCg       = 1'b1;
          ptr_d = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
        end
      end
      JUMP: begin
        o_prngCg = 1'b1;
        if (poly[k_q]) acc_d = acc_q ^ {i_prngS0, i_prngS1};
        k_d = k_q + 7'd1;
        if (k_q == 7'd127) state_d = LOAD;
      end
      default: state_d = UNSEEDED;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q    <= UNSEEDED;
      acc_q      <= '0;
      k_q        <= '0;
      long_q     <= 1'b0;
      ptr_q      <= '0;
      seed_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      k_q        <= k_d;
      long_q     <= long_d;
      ptr_q      <= ptr_d;
      seed_err_q <= seed_err_d;
    end
  end

  assign o_seedErr    = seed_err_q;
  assign o_data       = i_prngResult;
  assign o_prngSeedS0 = o_prngSeedValid ? acc_q[127:64] : '0;
  assign o_prngSeedS1 = o_prngSeedValid ? acc_q[63:0]   : '0;

endmodule

// File: tb/tb_prng_sequencer.sv
// Directed bench for prng_sequencer with a behavioural xoroshiro128+ generator attached.
module tb_prng_sequencer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        seed_valid;
  logic [63:0] seed_s0, seed_s1;
  logic        jump, long_jump;
  logic        busy, seed_err;
  logic [1:0]  req, gnt;
  logic [63:0] data;
  logic        prng_cg, prng_sv;
  logic [63:0] prng_seed_s0, prng_seed_s1;
  logic [63:0] g_s0 = '0, g_s1 = '0, g_res = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  prng_sequencer #(.N_REQ(2)) dut (
    .i_clk          (clk),
    .i_rstn         (rstn),
    .i_seedValid    (seed_valid),
    .i_seedS0       (seed_s0),
    .i_seedS1       (seed_s1),
    .i_jump         (jump),
    .i_longJump     (long_jump),
    .o_busy         (busy),
    .o_seedErr      (seed_err),
    .i_req          (req),
    .o_gnt          (gnt),
    .o_data         (data),
    .o_prngCg       (prng_cg),
    .o_prngSeedValid(prng_sv),
    .o_prngSeedS0   (prng_seed_s0),
    .o_prngSeedS1   (prng_seed_s1),
    .i_prngS0       (g_s0),
    .i_prngS1       (g_s1),
    .i_prngResult   (g_res)
  );

  function automatic logic [127:0] ref_next(input logic [127:0] s);
    logic [63:0] s0, t, n0, n1;
    s0 = s[127:64];
    t  = s[63:0] ^ s0;
    n0 = {s0[39:0], s0[63:40]} ^ t ^ (t << 16);
    n1 = {t[26:0], t[63:27]};
    return {n0, n1};
  endfunction

  function automatic logic [127:0] ref_jump(input logic [127:0] s, input logic [63:0] w0,
                                            input logic [63:0] w1);
    logic [127:0] acc, cur, p;
    acc = '0;
    cur = s;
    p   = {w1, w0};
    for (int i = 0; i < 128; i++) begin
      if (p[i]) acc = acc ^ cur;
      cur = ref_next(cur);
    end
    return acc;
  endfunction

  function automatic logic [63:0] sum_of(input logic [127:0] s);
    return s[127:64] + s[63:0];
  endfunction

  // External generator: load has priority over advance; result is registered.
  always @(posedge clk) begin
    if (prng_sv) begin
      g_s0 <= prng_seed_s0;
      g_s1 <= prng_seed_s1;
    end else if (prng_cg) begin
      g_res        <= g_s0 + g_s1;
      {g_s0, g_s1} <= ref_next({g_s0, g_s1});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [127:0] rs, jref, cap;
  logic [63:0]  w [4];
  int           n, bad, same;

  initial begin
    rstn = 1'b0; seed_valid = 1'b0; seed_s0 = '0; seed_s1 = '0;
    jump = 1'b0; long_jump = 1'b0; req = '0;
    tick; tick;
    check("rst_busy", busy, 0);
    check("rst_gnt", gnt, 0);
    check("rst_cg", prng_cg, 0);
    check("rst_sv", prng_sv, 0);
    check("rst_seederr", seed_err, 0);

    // All-zero seed rejected in UNSEEDED
    rstn = 1'b1; tick;
    seed_valid = 1'b1; #1;
    check("zseed_cg", prng_cg, 0);
    tick;
    seed_valid = 1'b0; #1;
    check("zseed_err_pulse", seed_err, 1);
    check("zseed_busy", busy, 0);
    check("zseed_cg2", prng_cg, 0);
    jump = 1'b1; req = 2'b01; #1;
    check("unseeded_gnt", gnt, 0);
    tick;
    jump = 1'b0; #1;
    check("zseed_err_single", seed_err, 0);
    check("unseeded_jump_ignored", busy, 0);

    // Seed 1,2 -> LOAD, PRIME, READY
    seed_valid = 1'b1; seed_s0 = 64'd1; seed_s1 = 64'd2; req = 2'b11; #1;
    tick;
    seed_valid = 1'b0; #1;
    check("load_busy", busy, 1);
    check("load_sv", prng_sv, 1);
    check("load_cg", prng_cg, 1);
    check("load_s0", prng_seed_s0, 64'd1);
    check("load_s1", prng_seed_s1, 64'd2);
    check("load_gnt", gnt, 0);
    tick;
    check("prime_sv", prng_sv, 0);
    check("prime_cg", prng_cg, 1);
    check("prime_s0_zero", prng_seed_s0, 0);
    check("prime_busy", busy, 1);
    check("prime_gnt", gnt, 0);
    tick;
    check("ready_busy", busy, 0);
    check("first_word", data, 64'd3);
    rs = {64'd1, 64'd2};
    for (int i = 0; i < 4; i++) begin
      check("rr_gnt", gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
      check("rr_cg", prng_cg, 1);
      check("rr_data", data, sum_of(rs));
      w[i] = data;
      if (i == 1) check("second_word", data, 64'h6001030003);
      rs = ref_next(rs);
      tick;
    end
    same = 0;
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (w[i] == w[j]) same++;
    check("words_distinct", same, 0);

    req = 2'b00; #1;
    check("idle_gnt", gnt, 0);
    check("idle_cg", prng_cg, 0);
    tick;
    req = 2'b10; #1;
    check("ptr0_only1_gnt", gnt, 2'b10);
    check("ptr0_only1_data", data, sum_of(rs));
    rs = ref_next(rs);
    tick;
    req = 2'b11; #1;
    check("ptr_wrap_gnt", gnt, 2'b01);
    check("ptr_wrap_data", data, sum_of(rs));
    rs = ref_next(rs);
    tick;

    // Seed and jump together in READY: seed wins, busy for 2 cycles
    seed_valid = 1'b1; seed_s0 = 64'h0123456789abcdef; seed_s1 = 64'hfedcba9876543210;
    jump = 1'b1; #1;
    check("cmd_suppress_gnt", gnt, 0);
    check("cmd_suppress_cg", prng_cg, 0);
    tick;
    seed_valid = 1'b0; jump = 1'b0; req = 2'b00; #1;
    n = 0; cap = '0;
    while (busy && n < 300) begin
      if (prng_sv) cap = {prng_seed_s0, prng_seed_s1};
      n++;
      tick;
    end
    check("seed_jump_busy", n, 2);
    check("seed_jump_loaded", cap, {64'h0123456789abcdef, 64'hfedcba9876543210});
    rs = {64'h0123456789abcdef, 64'hfedcba9876543210};

    // Jump with requests pending throughout
    jump = 1'b1; req = 2'b11; #1;
    check("jump_cmd_gnt", gnt, 0);
    tick;
    jump = 1'b0; #1;
    n = 0; bad = 0; cap = '0;
    while (busy && n < 300) begin
      if (prng_sv) cap = {prng_seed_s0, prng_seed_s1};
      if (gnt != 0) bad++;
      n++;
      tick;
    end
    jref = ref_jump(ref_next(rs), 64'hdf900294d8f554a5, 64'h170865df4b3201fc);
    check("jump_busy", n, 130);
    check("jump_state", cap, jref);
    check("jump_no_gnt", bad, 0);
    rs = jref;
    check("jump_pending_gnt", gnt, 2'b10);
    check("jump_data", data, sum_of(rs));
    rs = ref_next(rs);
    tick;

    // Long jump has priority over jump
    jump = 1'b1; long_jump = 1'b1; req = 2'b00; #1;
    tick;
    jump = 1'b0; long_jump = 1'b0; #1;
    n = 0; cap = '0;
    while (busy && n < 300) begin
      if (prng_sv) cap = {prng_seed_s0, prng_seed_s1};
      n++;
      tick;
    end
    jref = ref_jump(ref_next(rs), 64'hd2a98b26625eee7b, 64'hdddf9b1090aa7ac1);
    check("ljump_busy", n, 130);
    check("ljump_state", cap, jref);
    rs = jref;

    // Zero seed in READY: error pulse, state kept
    seed_valid = 1'b1; seed_s0 = '0; seed_s1 = '0; req = 2'b01; #1;
    check("ready_zseed_gnt", gnt, 0);
    tick;
    seed_valid = 1'b0; #1;
    check("ready_zseed_err", seed_err, 1);
    check("ready_zseed_busy", busy, 0);
    check("ready_zseed_gnt_after", gnt, 2'b01);
    check("ready_zseed_data", data, sum_of(rs));
    tick;
    req = 2'b00;

    // Seed ignored in JUMP, then reset at k=60
    jump = 1'b1; #1;
    tick;
    jump = 1'b0; #1;
    repeat (30) tick;
    seed_valid = 1'b1; seed_s0 = '0; seed_s1 = '0; #1;
    tick;
    seed_valid = 1'b0; #1;
    check("jump_seed_no_err", seed_err, 0);
    check("jump_seed_ignored", busy, 1);
    repeat (29) tick;
    rstn = 1'b0; req = 2'b11; #1;
    tick;
    check("midrst_busy", busy, 0);
    check("midrst_gnt", gnt, 0);
    check("midrst_cg", prng_cg, 0);
    check("midrst_sv", prng_sv, 0);
    check("midrst_seederr", seed_err, 0);
    check("midrst_seed_s0", prng_seed_s0, 0);
    rstn = 1'b1;
    tick;
    check("post_rst_gnt", gnt, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_cg", prng_cg, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prng_sequencer.md
PRNG_SEQUENCER -- requirements
Module: prng_sequencer

Interface
REQ-001 Parameter N_REQ, default 2: number of requesters sharing one xoroshiro128+ generator (2..8).
REQ-002 The block SHALL have exactly one clock; reset is synchronous and active-low.
REQ-003 i_clk  input  1  clock; all state updates on rising edge.
REQ-004 i_rstn  input  1  synchronous active-low reset.
REQ-005 i_seedValid  input  1  host seed command.
REQ-006 i_seedS0, i_seedS1  input  64 each  host seed words.
REQ-007 i_jump, i_longJump  input  1 each  host jump commands (level sampled in READY).
REQ-008 o_busy  output  1  high in every state except READY and UNSEEDED.
REQ-009 o_seedErr  output  1  one-cycle pulse on rejected all-zero seed.
REQ-010 i_req  input  N_REQ  per-requester request, held until granted.
REQ-011 o_gnt  output  N_REQ  one-hot grant; grant plus data form the transfer.
REQ-012 o_data  output  64  random word, equals i_prngResult, valid when any o_gnt bit is high.
REQ-013 o_prngCg  output  1  generator clock-enable (advance one step).
REQ-014 o_prngSeedValid  output  1  generator state load.
REQ-015 o_prngSeedS0, o_prngSeedS1  output  64 each  generator load values.
REQ-016 i_prngS0, i_prngS1, i_prngResult  input  64 each  generator state and registered result.

Function
REQ-017 States SHALL be UNSEEDED, LOAD, PRIME, READY, JUMP.
REQ-018 UNSEEDED: no grants, o_prngCg=0; accepted nonzero seed -> LOAD; i_jump/i_longJump ignored.
REQ-019 Seed with i_seedS0==0 and i_seedS1==0 SHALL be rejected: o_seedErr pulses next cycle, state unchanged.
REQ-020 Seed accepted only in UNSEEDED or READY; ignored in LOAD/PRIME/JUMP with no error.
REQ-021 LOAD (1 cycle): o_prngSeedValid=1, o_prngCg=1, seed values = latched host seed or jump accumulator; -> PRIME.
REQ-022 PRIME (1 cycle): o_prngCg=1, o_prngSeedValid=0, filling the generator's result register; -> READY.
REQ-023 READY: round-robin arbiter grants at most one requester per cycle; o_prngCg equals OR of o_gnt, so each transfer delivers a fresh word; sustained throughput one word per cycle.
REQ-024 Round-robin pointer SHALL start at requester 0 after reset and move to one past the last granted index; idle cycles do not move it.
REQ-025 READY priority in one cycle: seed > longJump > jump > requests; a command in READY suppresses that cycle's grant.
REQ-026 JUMP: 128 cycles, index k=0..127 over polynomial bits (word0 bits 0..63, then word1); if bit k set, acc ^= {i_prngS0,i_prngS1}; o_prngCg=1 every cycle; after k=127 -> LOAD with acc.
REQ-027 Jump polynomial = {0xdf900294d8f554a5, 0x170865df4b3201fc}; long-jump = {0xd2a98b26625eee7b, 0xdddf9b1090aa7ac1}; selected at JUMP entry and held.
REQ-028 Accumulator SHALL clear to zero on JUMP entry.
REQ-029 Requests during LOAD/PRIME/JUMP SHALL remain pending and be served in READY without loss.
REQ-030 o_prngSeedS0/S1 SHALL be zero when o_prngSeedValid is low.

Reset
REQ-031 On i_rstn low at a clock edge: state UNSEEDED, o_gnt=0, o_prngCg=0, o_prngSeedValid=0, o_seedErr=0, o_busy=0, acc=0, jump index=0, round-robin pointer=0.
REQ-032 Reset mid-JUMP or mid-LOAD SHALL abandon the operation; generator contents are then undefined and a new seed is required.

Verification
REQ-033 Seed S0=1,S1=2 from UNSEEDED -> LOAD then PRIME, READY on third cycle; first grant delivers o_data=3.
REQ-034 All-zero seed in UNSEEDED -> o_seedErr single pulse, state stays UNSEEDED, no o_prngCg.
REQ-035 Seeded READY, i_req=2'b11 held 4 cycles -> grants 01,10,01,10; o_prngCg high all 4 cycles; four distinct words.
REQ-036 Seed then i_jump -> o_busy high exactly 130 cycles; final state matches software xoroshiro128+ jump() reference from same seed.
REQ-037 i_seedValid and i_jump same cycle in READY -> seed loaded, jump ignored, o_busy for 2 cycles only.
REQ-038 Reset asserted at JUMP k=60 -> UNSEEDED next cycle, outputs at reset values, pending requests not granted.
